// File: rtl/issue_ctrl_pkg.sv
// Shared widths, scoreboard size and serialisation FSM encodings for the issue stage.
package issue_ctrl_pkg;

    localparam int WIDTH_UOP = 16;
    localparam int NREG      = 32;

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SERIAL = 2'd2;

    // True when a used source reads a non-zero destination register.
    function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                     input logic [4:0] rd);
        return use_src & (rd != 5'd0) & (src == rd);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy scoreboard: two set ports (issue), two clear ports (writeback), flush.
// Lookups are combinational and see same-cycle writeback clears; r0 is never busy.
module issue_scoreboard #(
    parameter int NREG = issue_ctrl_pkg::NREG
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            set0_vld,
    input  logic [4:0]      set0_rd,
    input  logic            set1_vld,
    input  logic [4:0]      set1_rd,
    input  logic            clr0_vld,
    input  logic [4:0]      clr0_rd,
    input  logic            clr1_vld,
    input  logic [4:0]      clr1_rd,
    input  logic [3:0][4:0] src_idx,
    output logic [3:0]      src_busy,
    output logic            all_clear
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (clr0_vld) clr_mask[clr0_rd] = 1'b1;
        if (clr1_vld) clr_mask[clr1_rd] = 1'b1;
        if (set0_vld) set_mask[set0_rd] = 1'b1;
        if (set1_vld) set_mask[set1_rd] = 1'b1;

        // Set is applied after clear so a reissued destination stays busy.
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
        if (flush) busy_d = '0;

        for (int i = 0; i < 4; i++) begin
            src_busy[i] = busy_q[src_idx[i]] & ~clr_mask[src_idx[i]] & (src_idx[i] != 5'd0);
        end
        all_clear = ~|busy_q;
    end

    always_ff @(posedge clk) begin
        if (rstn) busy_q <= '0;
        else      busy_q <= busy_d;
    end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue select stage: issues 0..2 oldest IQ entries in order into a registered EX latch.
// issue_cnt is combinational back to the IQ; the latch stalls while EX holds it (ex_ready=0).
module issue_ctrl #(
    parameter int NREG  = issue_ctrl_pkg::NREG,
    parameter int UOP_W = issue_ctrl_pkg::WIDTH_UOP
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             iq_valid0,
    input  logic             iq_valid1,
    input  logic [UOP_W-1:0] iq_uop0,
    input  logic [UOP_W-1:0] iq_uop1,
    input  logic [4:0]       iq_rd0,
    input  logic [4:0]       iq_rd1,
    input  logic [4:0]       iq_rj0,
    input  logic [4:0]       iq_rj1,
    input  logic [4:0]       iq_rk0,
    input  logic [4:0]       iq_rk1,
    input  logic             iq_use_rj0,
    input  logic             iq_use_rj1,
    input  logic             iq_use_rk0,
    input  logic             iq_use_rk1,
    input  logic             iq_is_ALU0,
    input  logic             iq_is_ALU1,
    input  logic             iq_serial0,
    input  logic             iq_serial1,
    output logic [1:0]       issue_cnt,
    input  logic             ex_ready,
    input  logic             ex_idle,
    input  logic             priv_done,
    input  logic             wb0_valid,
    input  logic             wb1_valid,
    input  logic [4:0]       wb0_rd,
    input  logic [4:0]       wb1_rd,
    output logic             ex_valid0,
    output logic             ex_valid1,
    output logic [UOP_W-1:0] ex_uop0,
    output logic [UOP_W-1:0] ex_uop1,
    output logic [4:0]       ex_rd0,
    output logic [4:0]       ex_rd1,
    output logic [4:0]       ex_rj0,
    output logic [4:0]       ex_rj1,
    output logic [4:0]       ex_rk0,
    output logic [4:0]       ex_rk1
);
    import issue_ctrl_pkg::*;

    logic [1:0]       state_q, state_d;
    logic             ex_valid0_q, ex_valid0_d, ex_valid1_q, ex_valid1_d;
    logic [UOP_W-1:0] ex_uop0_q, ex_uop0_d, ex_uop1_q, ex_uop1_d;
    logic [4:0]       ex_rd0_q, ex_rd0_d, ex_rd1_q, ex_rd1_d;
    logic [4:0]       ex_rj0_q, ex_rj0_d, ex_rj1_q, ex_rj1_d;
    logic [4:0]       ex_rk0_q, ex_rk0_d, ex_rk1_q, ex_rk1_d;

    logic       adv, ready0, ready1, raw, pair_ok, issue0, issue1;
    logic [3:0] src_busy;
    logic       all_clear;

    issue_scoreboard #(.NREG(NREG)) u_sb (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .set0_vld  (issue0 & ~iq_is_ALU0),
        .set0_rd   (iq_rd0),
        .set1_vld  (issue1 & ~iq_is_ALU1),
        .set1_rd   (iq_rd1),
        .clr0_vld  (wb0_valid),
        .clr0_rd   (wb0_rd),
        .clr1_vld  (wb1_valid),
        .clr1_rd   (wb1_rd),
        .src_idx   ({iq_rk1, iq_rj1, iq_rk0, iq_rj0}),
        .src_busy  (src_busy),
        .all_clear (all_clear)
    );

    always_comb begin
        adv     = ex_ready | ~ex_valid0_q;
        ready0  = ~(iq_use_rj0 & src_busy[0]) & ~(iq_use_rk0 & src_busy[1]);
        ready1  = ~(iq_use_rj1 & src_busy[2]) & ~(iq_use_rk1 & src_busy[3]);
        raw     = src_hit(iq_use_rj1, iq_rj1, iq_rd0) | src_hit(iq_use_rk1, iq_rk1, iq_rd0);
        // Only one LSU/MUL pipe, so at least one of the pair must be an ALU op.
        pair_ok = iq_valid1 & ready1 & ~iq_serial1 & ~raw & (iq_is_ALU0 | iq_is_ALU1);

        issue0  = 1'b0;
        issue1  = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_NORMAL: begin
                if (iq_valid0 & iq_serial0) begin
                    state_d = ST_DRAIN;
                end else if (adv & iq_valid0 & ready0) begin
                    issue0 = 1'b1;
                    issue1 = pair_ok;
                end
            end
            ST_DRAIN: begin
                if (iq_valid0 & all_clear & ex_idle & ~ex_valid0_q & adv) begin
                    issue0  = 1'b1;
                    state_d = ST_SERIAL;
                end
            end
            ST_SERIAL: begin
                if (priv_done) state_d = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase

        if (rstn | flush) begin
            issue0  = 1'b0;
            issue1  = 1'b0;
            state_d = ST_NORMAL;
        end
        issue_cnt = {1'b0, issue0} + {1'b0, issue1};
    end

    always_comb begin
        ex_valid0_d = ex_valid0_q;
        ex_valid1_d = ex_valid1_q;
        ex_uop0_d   = ex_uop0_q;
        ex_uop1_d   = ex_uop1_q;
        ex_rd0_d    = ex_rd0_q;
        ex_rd1_d    = ex_rd1_q;
        ex_rj0_d    = ex_rj0_q;
        ex_rj1_d    = ex_rj1_q;
        ex_rk0_d    = ex_rk0_q;
        ex_rk1_d    = ex_rk1_q;
        if (flush) begin
            ex_valid0_d = 1'b0;
            ex_valid1_d = 1'b0;
            ex_uop0_d   = '0;
            ex_uop1_d   = '0;
            ex_rd0_d    = '0;
            ex_rd1_d    = '0;
            ex_rj0_d    = '0;
            ex_rj1_d    = '0;
            ex_rk0_d    = '0;
            ex_rk1_d    = '0;
        end else if (adv) begin
            ex_valid0_d = issue0;
            ex_valid1_d = issue1;
            ex_uop0_d   = iq_uop0;
            ex_uop1_d   = iq_uop1;
            ex_rd0_d    = iq_rd0;
            ex_rd1_d    = iq_rd1;
            ex_rj0_d    = iq_rj0;
            ex_rj1_d    = iq_rj1;
            ex_rk0_d    = iq_rk0;
            ex_rk1_d    = iq_rk1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= ST_NORMAL;
            ex_valid0_q <= 1'b0;
            ex_valid1_q <= 1'b0;
            ex_uop0_q   <= '0;
            ex_uop1_q   <= '0;
            ex_rd0_q    <= '0;
            ex_rd1_q    <= '0;
            ex_rj0_q    <= '0;
            ex_rj1_q    <= '0;
            ex_rk0_q    <= '0;
            ex_rk1_q    <= '0;
        end else begin
            state_q     <= state_d;
            ex_valid0_q <= ex_valid0_d;
            ex_valid1_q <= ex_valid1_d;
            ex_uop0_q   <= ex_uop0_d;
            ex_uop1_q   <= ex_uop1_d;
            ex_rd0_q    <= ex_rd0_d;
            ex_rd1_q    <= ex_rd1_d;
            ex_rj0_q    <= ex_rj0_d;
            ex_rj1_q    <= ex_rj1_d;
            ex_rk0_q    <= ex_rk0_d;
            ex_rk1_q    <= ex_rk1_d;
        end
    end

    assign ex_valid0 = ex_valid0_q;
    assign ex_valid1 = ex_valid1_q;
    assign ex_uop0   = ex_uop0_q;
    assign ex_uop1   = ex_uop1_q;
    assign ex_rd0    = ex_rd0_q;
    assign ex_rd1    = ex_rd1_q;
    assign ex_rj0    = ex_rj0_q;
    assign ex_rj1    = ex_rj1_q;
    assign ex_rk0    = ex_rk0_q;
    assign ex_rk1    = ex_rk1_q;

endmodule
